// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seg_scan_mux display scanner.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Wide enough for any practical digit count; callers take the low bits.
    localparam logic [31:0] ANODE_OFF = '1;
    localparam logic [3:0]  BCD_ZERO  = 4'h0;

endpackage

// File: rtl/seg_scan_tick.sv
// Scan prescaler: one-cycle tick every TICK_DIV clocks while en is high.
module seg_scan_tick #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scan driver with per-digit dead-time.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 100,
    parameter int ON_TICKS    = 240,
    parameter int BLANK_TICKS = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [3:0]                    number,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXT = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int TW   = $clog2(MAXT + 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    state_t                  state;
    logic                    tick;
    logic [TW-1:0]           tick_count;
    logic [4*NUM_DIGITS-1:0] lat_digits;
    logic [NUM_DIGITS-1:0]   lat_mask;
    logic [NUM_DIGITS-1:0]   next_mask;
    logic [IW-1:0]           next_idx;
    logic [3:0]              next_number;
    logic [NUM_DIGITS-1:0]   show_an;

    // The prescaler free-runs from en, so the first BLANK after IDLE can be
    // shorter than later ones; every subsequent period is tick-aligned.
    seg_scan_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic lead;
        next_mask = blank_mask;
        lead      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead = lead && (digits[4*k +: 4] == BCD_ZERO);
            if (lead) next_mask[k] = 1'b1;
        end
    end
`else
    assign next_mask = blank_mask;
`endif

    assign next_idx    = digit_idx + IW'(1);
    assign next_number = lat_digits[4*next_idx +: 4];

    always_comb begin
        show_an = AN_OFF;
        if (!lat_mask[digit_idx]) show_an[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_count <= '0;
            an         <= AN_OFF;
            number     <= BCD_ZERO;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            lat_digits <= '0;
            lat_mask   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state      <= IDLE;
                tick_count <= '0;
                an         <= AN_OFF;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= BLANK;
                        tick_count <= '0;
                        an         <= AN_OFF;
                        digit_idx  <= '0;
                        lat_digits <= digits;
                        lat_mask   <= next_mask;
                        number     <= digits[3:0];
                    end
                    BLANK: begin
                        if (tick) begin
                            if (tick_count == BLANK_LAST) begin
                                state      <= SHOW;
                                tick_count <= '0;
                                an         <= show_an;
                            end else begin
                                tick_count <= tick_count + TW'(1);
                            end
                        end
                    end
                    SHOW: begin
                        if (tick) begin
                            if (tick_count == ON_LAST) begin
                                state      <= BLANK;
                                tick_count <= '0;
                                an         <= AN_OFF;
                                if (digit_idx == IDX_LAST) begin
                                    // Frame boundary: re-latch so the next frame is coherent.
                                    frame_done <= 1'b1;
                                    digit_idx  <= '0;
                                    lat_digits <= digits;
                                    lat_mask   <= next_mask;
                                    number     <= digits[3:0];
                                end else begin
                                    digit_idx  <= next_idx;
                                    number     <= next_number;
                                end
                            end else begin
                                tick_count <= tick_count + TW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        an    <= AN_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: expected output runs (tuple + length in cycles)
// are queued up front and a negedge monitor compares each run as it ends.
module tb_seg_scan_mux;
    localparam int N  = 4;
    localparam int TD = 2;
    localparam int ON = 3;
    localparam int BL = 1;
    localparam int W  = 19;   // {an[3:0], number[3:0], idx[1:0], frame_done, len[7:0]}

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  number;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [10:0]  pend_t;
    int           pend_len;
    bit           pend_have = 1'b0;

    logic         mon_active = 1'b0;
    logic [10:0]  run_t;
    logic [10:0]  cur_t;
    int           run_len;
    bit           run_have = 1'b0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS  (N),
        .TICK_DIV    (TD),
        .ON_TICKS    (ON),
        .BLANK_TICKS (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits     (digits),
        .blank_mask (blank_mask),
        .number     (number),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected-run builder: consecutive identical output tuples merge into one run.
    task automatic add_seg(input logic [3:0] a, input logic [3:0] nm, input logic [1:0] ix,
                           input logic fd, input int len);
        logic [10:0] t;
        t = {a, nm, ix, fd};
        if (pend_have && t == pend_t) begin
            pend_len += len;
        end else begin
            if (pend_have) exp_q.push_back({pend_t, 8'(pend_len)});
            pend_t    = t;
            pend_len  = len;
            pend_have = 1'b1;
        end
    endtask

    task automatic flush_exp();
        if (pend_have) exp_q.push_back({pend_t, 8'(pend_len)});
        pend_have = 1'b0;
    endtask

    // One full frame: BLANK is 2 cycles, SHOW 6; after IDLE the first BLANK is 1 cycle,
    // after a previous frame its first cycle carries the frame_done pulse.
    task automatic exp_frame(input logic [15:0] d, input logic [3:0] m, input bit after_frame);
        logic [3:0] nib;
        logic [3:0] a;
        for (int k = 0; k < N; k++) begin
            nib = d[4*k +: 4];
            if (k == 0 && after_frame) begin
                add_seg(4'hF, nib, 2'(k), 1'b1, 1);
                add_seg(4'hF, nib, 2'(k), 1'b0, 1);
            end else if (k == 0) begin
                add_seg(4'hF, nib, 2'(k), 1'b0, 1);
            end else begin
                add_seg(4'hF, nib, 2'(k), 1'b0, 2);
            end
            a = m[k] ? 4'hF : ~(4'b0001 << k);
            add_seg(a, nib, 2'(k), 1'b0, 6);
        end
    endtask

    task automatic check_run();
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL run: actual %h len %0d, required nothing (queue empty)", run_t, run_len);
        end else begin
            e = exp_q.pop_front();
            if (e !== {run_t, 8'(run_len)}) begin
                errors++;
                $display("FAIL run: actual an=%h num=%h idx=%0d fd=%0b len=%0d required an=%h num=%h idx=%0d fd=%0b len=%0d",
                         run_t[10:7], run_t[6:3], run_t[2:1], run_t[0], run_len,
                         e[18:15], e[14:11], e[10:9], e[8], e[7:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        cur_t = {an, number, digit_idx, frame_done};
        if (mon_active) begin
            if (run_have && cur_t == run_t) begin
                run_len++;
            end else begin
                if (run_have) check_run();
                run_t    = cur_t;
                run_len  = 1;
                run_have = 1'b1;
            end
        end else if (run_have) begin
            check_run();
            run_have = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        digits     = 16'h0000;
        blank_mask = 4'b0000;

        #12;
        chk("reset_an", an, 4'hF);
        chk("reset_number", number, 4'h0);
        chk("reset_idx", digit_idx, 2'd0);
        chk("reset_fd", frame_done, 1'b0);

        @(posedge clk); #1;
        reset = 1'b0;
        step(2);
        chk("idle_an", an, 4'hF);
        chk("idle_fd", frame_done, 1'b0);

        // Expected timeline, measured from the edge that first samples en=1.
        add_seg(4'hF, 4'h0, 2'd0, 1'b0, 1);
        exp_frame(16'h1234, 4'b0000, 1'b0);
        exp_frame(16'h5678, 4'b0000, 1'b1);
        exp_frame(16'h1234, 4'b0100, 1'b1);
        add_seg(4'hF, 4'h4, 2'd0, 1'b1, 1);
        add_seg(4'hF, 4'h4, 2'd0, 1'b0, 1);
        add_seg(4'hE, 4'h4, 2'd0, 1'b0, 6);
        add_seg(4'hF, 4'h3, 2'd1, 1'b0, 2);
        add_seg(4'hD, 4'h3, 2'd1, 1'b0, 6);
        add_seg(4'hF, 4'h2, 2'd2, 1'b0, 2);
        add_seg(4'hB, 4'h2, 2'd2, 1'b0, 3);   // en drops mid-SHOW
        add_seg(4'hF, 4'h2, 2'd2, 1'b0, 4);   // IDLE: number/idx hold, no frame_done
        add_seg(4'hF, 4'h4, 2'd0, 1'b0, 1);   // restart at digit 0
        add_seg(4'hE, 4'h4, 2'd0, 1'b0, 6);
        flush_exp();

        @(posedge clk); #1;
        en         = 1'b1;
        digits     = 16'h1234;
        mon_active = 1'b1;
        step(11);
        digits = 16'h5678;                    // during digit 1 SHOW of frame 1
        step(30);
        digits     = 16'h1234;                // during frame 2, latched at its end
        blank_mask = 4'b0100;
        step(30);
        blank_mask = 4'b0000;                 // during frame 3, latched at its end
        step(45);
        en = 1'b0;                            // during digit 2 SHOW of frame 4
        step(4);
        en = 1'b1;
        step(8);
        mon_active = 1'b0;

        step(3);
        chk("pre_reset_an", an, 4'hD);
        reset = 1'b1;
        #2;
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_number", number, 4'h0);
        chk("async_reset_idx", digit_idx, 2'd0);
        chk("async_reset_fd", frame_done, 1'b0);

        step(2);
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
